// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state control unit for the 32-bit bus datapath
module control_sequencer #(
    parameter int              OPW     = 5,
    parameter logic [OPW-1:0]  ALU_ADD = OPW'(3)
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic           Run,
    input  logic [31:0]    IR,
    input  logic           CON,
    input  logic           Mem_ready,
    output logic           PCout, Zlowout, Zhiout, MDRout, HIout, LOout,
    output logic           Cout, InPortout, BAout, Rout,
    output logic           PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin,
    output logic           Rin, CONin, IncPC, Read, Write,
    output logic           Gra, Grb, Grc,
    output logic [OPW-1:0] ALUop,
    output logic [3:0]     Step,
    output logic           Halted,
    output logic           Illegal
);

    // T-states encode their own index so Step can be read straight from the state
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_HALTED = 4'd14, S_IDLE = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALUR, C_ALUI, C_BR, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t         state, state_nxt;
    cls_t           cls;
    logic [OPW-1:0] op;
    logic [31:0]    opv;
    logic           unused_ir;

    assign op        = IR[31:32-OPW];
    assign opv       = {{(32-OPW){1'b0}}, op};
    assign unused_ir = ^IR[31-OPW:0];

    always_comb begin
        cls = C_ILL;
        if (opv == 32'd0)                        cls = C_LD;
        else if (opv == 32'd1)                   cls = C_LDI;
        else if (opv == 32'd2)                   cls = C_ST;
        else if (opv >= 32'd3 && opv <= 32'd11)  cls = C_ALUR;
        else if (opv >= 32'd12 && opv <= 32'd14) cls = C_ALUI;
        else if (opv == 32'd18)                  cls = C_BR;
        else if (opv == 32'd26)                  cls = C_NOP;
        else if (opv == 32'd27)                  cls = C_HALT;
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALTED: if (Run) state_nxt = S_T0;
            S_T0: state_nxt = S_T1;
            S_T1: if (Mem_ready) state_nxt = S_T2;
            S_T2: state_nxt = S_T3;
            S_T3: begin
                if (cls == C_NOP || cls == C_ILL) state_nxt = S_T0;
                else if (cls == C_HALT)           state_nxt = S_HALTED;
                else                              state_nxt = S_T4;
            end
            S_T4: state_nxt = S_T5;
            S_T5: begin
                if (cls == C_LD || cls == C_ST || cls == C_BR) state_nxt = S_T6;
                else                                           state_nxt = S_T0;
            end
            S_T6: begin
                if (cls == C_BR)                   state_nxt = S_T0;
                else if (cls == C_ST || Mem_ready) state_nxt = S_T7;
            end
            S_T7: if (cls != C_ST || Mem_ready) state_nxt = S_T0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout} = '0;
        {PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin, CONin, IncPC, Read, Write} = '0;
        {Gra, Grb, Grc} = '0;
        ALUop   = '0;
        Illegal = 1'b0;
        Halted  = (state == S_HALTED);
        Step    = (state == S_IDLE || state == S_HALTED) ? 4'd15 : state;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_ALUR, C_ALUI:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_ILL:             Illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    C_ALUR:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op; end
                    C_ALUI:            begin Cout = 1'b1; Zin = 1'b1; ALUop = op; end
                    C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_LD, C_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_LDI, C_ALUR, C_ALUI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR:                  begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_BR: begin Zlowout = 1'b1; PCin = CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - vector table plus directed multi-cycle sequences for control_sequencer
module tb_control_sequencer;

    logic        Clock, Clear, Run, CON, Mem_ready;
    logic [31:0] IR;
    logic PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin, CONin, IncPC, Read, Write;
    logic Gra, Grb, Grc, Halted, Illegal;
    logic [4:0]  ALUop;
    logic [3:0]  Step;
    logic [27:0] sig;

    control_sequencer #(.OPW(5), .ALU_ADD(5'b00011)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .CON(CON), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout), .HIout(HIout),
        .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin), .IncPC(IncPC), .Read(Read),
        .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALUop(ALUop), .Step(Step),
        .Halted(Halted), .Illegal(Illegal)
    );

    assign sig = {PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout,
                  PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin, CONin, IncPC, Read,
                  Write, Gra, Grb, Grc, Halted, Illegal};

    localparam logic [27:0] PCOUT  = 28'd1 << 27, ZLOW  = 28'd1 << 26, MDROUT = 28'd1 << 24;
    localparam logic [27:0] COUT   = 28'd1 << 21, BAOUT = 28'd1 << 19, ROUT   = 28'd1 << 18;
    localparam logic [27:0] PCIN   = 28'd1 << 17, IRIN  = 28'd1 << 16, YIN    = 28'd1 << 15;
    localparam logic [27:0] ZIN    = 28'd1 << 14, MARIN = 28'd1 << 13, MDRIN  = 28'd1 << 12;
    localparam logic [27:0] RIN    = 28'd1 << 9,  CONIN = 28'd1 << 8,  INCPC  = 28'd1 << 7;
    localparam logic [27:0] READ   = 28'd1 << 6,  WRITE = 28'd1 << 5,  GRA    = 28'd1 << 4;
    localparam logic [27:0] GRB    = 28'd1 << 3,  GRC   = 28'd1 << 2,  HALTB  = 28'd1 << 1;
    localparam logic [27:0] ILL    = 28'd1;
    localparam logic [27:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [27:0] F1 = ZLOW | PCIN | READ | MDRIN;
    localparam logic [27:0] F2 = MDROUT | IRIN;

    typedef struct {
        logic        run;
        logic [31:0] ir;
        logic        con;
        logic        mr;
        logic [3:0]  step;
        logic [27:0] sig;
        logic [4:0]  alu;
    } vec_t;

    vec_t        vecs [64];
    int          nv;
    int          n_checks, n_fail;
    logic [27:0] seen [16];
    logic [4:0]  seen_alu [16];
    int          rd6, ill_cnt, len;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Two bus drivers or Read with Write in the same cycle would be a bus fight
    always @(negedge Clock) begin
        n_checks++;
        if ($countones(sig[27:18]) > 1 || (Read && Write)) begin
            n_fail++;
            $display("FAIL bus_exclusive: drivers 0x%0h read %0b write %0b, expected at most one driver",
                     sig[27:18], Read, Write);
        end
    end

    task automatic add(input logic run, input logic [31:0] ir, input logic mr,
                       input logic [3:0] st, input logic [27:0] s, input logic [4:0] alu);
        vecs[nv] = '{run: run, ir: ir, con: 1'b0, mr: mr, step: st, sig: s, alu: alu};
        nv++;
    endtask

    task automatic fetch(input logic [31:0] ir);
        add(1'b0, ir, 1'b1, 4'd0, F0, 5'd0);
        add(1'b0, ir, 1'b1, 4'd1, F1, 5'd0);
        add(1'b0, ir, 1'b1, 4'd2, F2, 5'd0);
    endtask

    // Runs one instruction from T0 until the next T0 or HALTED, stalling stall_step nstall cycles
    task automatic run_instr(input logic [31:0] ir, input logic c, input int stall_step,
                             input int nstall);
        int  stalls;
        bit  done;
        logic [3:0] st;
        IR = ir; CON = c; Run = 1'b0; Mem_ready = 1'b1;
        stalls = nstall; rd6 = 0; ill_cnt = 0; len = 0; done = 1'b0;
        for (int i = 0; i < 16; i++) begin seen[i] = '0; seen_alu[i] = '0; end
        while (!done) begin
            @(negedge Clock);
            len++;
            st = Step;
            seen[st] = sig;
            seen_alu[st] = ALUop;
            if (st == 4'd6 && Read && MDRin) rd6++;
            if (Illegal) ill_cnt++;
            if (int'(st) == stall_step && stalls > 0) begin
                Mem_ready = 1'b0;
                stalls--;
            end else begin
                Mem_ready = 1'b1;
            end
            @(posedge Clock); #1;
            if (Step == 4'd0 || Step == 4'd15 || len >= 40) done = 1'b1;
        end
    endtask

    localparam logic [31:0] I_LDI  = 32'h0880_0005;
    localparam logic [31:0] I_LD   = 32'h0120_0000;
    localparam logic [31:0] I_ST   = 32'h1000_0000;
    localparam logic [31:0] I_ALUR = 32'h5800_0000;
    localparam logic [31:0] I_ALUI = 32'h6000_0000;
    localparam logic [31:0] I_BR   = 32'h9000_0000;
    localparam logic [31:0] I_NOP  = 32'hD000_0000;
    localparam logic [31:0] I_HALT = 32'hD800_0000;
    localparam logic [31:0] I_IL15 = 32'h7800_0000;
    localparam logic [31:0] I_IL31 = 32'hF800_0000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; nv = 0;
        Clear = 1'b0; Run = 1'b0; IR = '0; CON = 1'b0; Mem_ready = 1'b1;
        #2 Clear = 1'b1;
        #1;
        chk("reset_step", 32'(Step), 32'd15);
        chk("reset_sig", 32'(sig), 32'd0);
        chk("reset_alu", 32'(ALUop), 32'd0);
        repeat (2) @(posedge Clock);
        #1 Clear = 1'b0;

        add(1'b0, I_LDI, 1'b1, 4'd15, 28'd0, 5'd0);
        add(1'b1, I_LDI, 1'b1, 4'd15, 28'd0, 5'd0);
        add(1'b0, I_LDI, 1'b1, 4'd0, F0, 5'd0);
        add(1'b0, I_LDI, 1'b0, 4'd1, F1, 5'd0);
        add(1'b0, I_LDI, 1'b1, 4'd1, F1, 5'd0);
        add(1'b0, I_LDI, 1'b1, 4'd2, F2, 5'd0);
        add(1'b0, I_LDI, 1'b1, 4'd3, GRB | BAOUT | YIN, 5'd0);
        add(1'b0, I_LDI, 1'b1, 4'd4, COUT | ZIN, 5'd3);
        add(1'b0, I_LDI, 1'b1, 4'd5, ZLOW | GRA | RIN, 5'd0);
        fetch(I_ALUR);
        add(1'b0, I_ALUR, 1'b1, 4'd3, GRB | ROUT | YIN, 5'd0);
        add(1'b0, I_ALUR, 1'b1, 4'd4, GRC | ROUT | ZIN, 5'd11);
        add(1'b0, I_ALUR, 1'b1, 4'd5, ZLOW | GRA | RIN, 5'd0);
        fetch(I_ALUI);
        add(1'b0, I_ALUI, 1'b1, 4'd3, GRB | ROUT | YIN, 5'd0);
        add(1'b0, I_ALUI, 1'b1, 4'd4, COUT | ZIN, 5'd12);
        add(1'b0, I_ALUI, 1'b1, 4'd5, ZLOW | GRA | RIN, 5'd0);
        fetch(I_NOP);
        add(1'b0, I_NOP, 1'b1, 4'd3, 28'd0, 5'd0);
        fetch(I_IL15);
        add(1'b0, I_IL15, 1'b1, 4'd3, ILL, 5'd0);

        for (int i = 0; i < nv; i++) begin
            Run = vecs[i].run; IR = vecs[i].ir; CON = vecs[i].con; Mem_ready = vecs[i].mr;
            @(negedge Clock);
            chk($sformatf("vec%0d_step", i), 32'(Step), 32'(vecs[i].step));
            chk($sformatf("vec%0d_sig", i), 32'(sig), 32'(vecs[i].sig));
            chk($sformatf("vec%0d_alu", i), 32'(ALUop), 32'(vecs[i].alu));
            @(posedge Clock); #1;
        end

        run_instr(I_LD, 1'b0, 6, 3);
        chk("ld_len", len, 11);
        chk("ld_read_t6", rd6, 4);
        chk("ld_t4", 32'({seen[4], seen_alu[4]}), 32'({COUT | ZIN, 5'd3}));
        chk("ld_t5", 32'(seen[5]), 32'(ZLOW | MARIN));
        chk("ld_t7", 32'(seen[7]), 32'(MDROUT | GRA | RIN));

        run_instr(I_ST, 1'b0, 7, 2);
        chk("st_len", len, 10);
        chk("st_t6", 32'(seen[6]), 32'(GRA | ROUT | MDRIN));
        chk("st_t7", 32'(seen[7]), 32'(WRITE));

        run_instr(I_BR, 1'b1, -1, 0);
        chk("br1_len", len, 7);
        chk("br1_t3", 32'(seen[3]), 32'(GRA | ROUT | CONIN));
        chk("br1_t4", 32'(seen[4]), 32'(PCOUT | YIN));
        chk("br1_t5", 32'({seen[5], seen_alu[5]}), 32'({COUT | ZIN, 5'd3}));
        chk("br1_t6", 32'(seen[6]), 32'(ZLOW | PCIN));

        run_instr(I_BR, 1'b0, -1, 0);
        chk("br0_len", len, 7);
        chk("br0_t6", 32'(seen[6]), 32'(ZLOW));
        chk("br0_next", 32'(Step), 32'd0);

        run_instr(I_IL31, 1'b0, -1, 0);
        chk("ill_len", len, 4);
        chk("ill_t3", 32'(seen[3]), 32'(ILL));
        chk("ill_pulses", ill_cnt, 1);

        run_instr(I_HALT, 1'b0, -1, 0);
        chk("halt_len", len, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk($sformatf("halt_hold%0d", i), 32'({Step, sig}), 32'({4'd15, HALTB}));
        end
        Run = 1'b1;
        @(posedge Clock); #1;
        chk("halt_resume", 32'({Step, sig}), 32'({4'd0, F0}));

        Run = 1'b0; IR = I_LDI; Mem_ready = 1'b1;
        repeat (5) @(posedge Clock);
        #1;
        chk("pre_clear_step", 32'(Step), 32'd5);
        #2 Clear = 1'b1;
        #1;
        chk("clear_async_sig", 32'(sig), 32'd0);
        chk("clear_async_step", 32'(Step), 32'd15);
        chk("clear_async_alu", 32'(ALUop), 32'd0);
        @(posedge Clock); #1;
        chk("clear_hold_step", 32'(Step), 32'd15);
        Clear = 1'b0; Run = 1'b1;
        @(posedge Clock); #1;
        chk("clear_restart", 32'({Step, sig}), 32'({4'd0, F0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus-based datapath. It steps a T-state machine through fetch and then instruction-specific execute steps, decoded from the IR opcode. Each cycle it drives the single-cycle register and bus control strobes, replacing hand-sequenced per-instruction stimulus. It supports loads, stores, immediate and register ALU ops, and conditional branch, and it stalls on a memory-ready handshake.

## Interface
- OPW, 5, opcode width, taken from IR[31:32-OPW]
- ALU_ADD, 5'b00011, ALUop code driven for address/immediate/branch-offset adds
- Clock  in  1  rising-edge clock
- Clear  in  1  asynchronous, active-high reset
- Run  in  1  level; start from IDLE, resume from HALTED
- IR  in  32  instruction register contents (valid from T3 on)
- CON  in  1  branch condition flag from CON FF (sampled in T6 of BR)
- Mem_ready  in  1  memory handshake; high = current Read/Write completes this cycle
- PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout  out  1 each  bus-drive strobes
- PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin, CONin, IncPC, Read, Write  out  1 each  load/control strobes
- Gra, Grb, Grc  out  1 each  register-field select
- ALUop  out  OPW  ALU function for the cycle Zin is high; 0 otherwise
- Step  out  4  current T index (0–7); 15 in IDLE/HALTED
- Halted  out  1  high in HALTED
- Illegal  out  1  one-cycle pulse on undecoded opcode

## Operation
- States: IDLE, T0–T7, HALTED. Outputs are a Moore decode of the state; unlisted strobes are 0.
- On Clear: state goes to IDLE and all outputs go to 0, with Step=15.
- IDLE→T0 when Run=1. HALTED→T0 when Run=1, else it holds with Halted=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcode classes (op=IR[31:27]):
  - LD=0, LDI=1, ST=2.
  - ALU_R=3..11, with ALUop=op.
  - ALU_I=12..14, with ALUop=op.
  - BR=18, NOP=26, HALT=27.
  - Any other opcode is illegal.
- LDI:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALUop=ALU_ADD.
  - T5: Zlowout, Gra, Rin.
  - Then →T0.
- LD:
  - T3–T4 as LDI.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
  - Then →T0.
- ST:
  - T3–T5 as LD.
  - T6: Gra, Rout, MDRin.
  - T7: Write.
  - Then →T0.
- ALU_R:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALUop=op.
  - T5: Zlowout, Gra, Rin.
  - Then →T0.
- ALU_I:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, ALUop=op.
  - T5: Zlowout, Gra, Rin.
  - Then →T0.
- BR:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, ALUop=ALU_ADD.
  - T6: Zlowout, and PCin=CON.
  - Then →T0.
- NOP: T3 with no strobes, then →T0.
- HALT: T3 with no strobes, then →HALTED.
- Illegal opcode: T3 with no strobes and Illegal=1, then →T0.

## Timing
- Each T-state lasts one cycle, except memory states (T1 fetch, LD T6, ST T7), which hold with strobes asserted until a cycle with Mem_ready=1. The transition happens on that edge.
- Instruction length with zero wait (Mem_ready tied 1):
  - LDI, ALU_R, ALU_I: 6 cycles.
  - BR: 7 cycles.
  - LD, ST: 8 cycles.
  - NOP, HALT, illegal: 4 cycles.
- The decode uses IR sampled in T3 and each subsequent cycle. IR must remain stable until T0, which is guaranteed because IRin is asserted only in T2.
- Run is ignored outside IDLE/HALTED. Deasserting Run mid-instruction does not stop it.
- Clear asynchronously forces IDLE at any point, including mid-memory-stall. Outputs drop to 0 without waiting for a clock edge.
- No state ever asserts two bus-drive strobes simultaneously. The bench checks this every cycle.

## Test plan
- Reset: Clear=1 mid-T5 of LDI → all strobes 0 immediately, Step=15. After release with Run=1, T0 in the next cycle with PCout=MARin=IncPC=Zin=1.
- LDI, IR=0x08800005 (op=1), Mem_ready=1 → T3 Grb/BAout/Yin, T4 Cout/Zin/ALUop=3, T5 Zlowout/Gra/Rin, T0 at cycle 7.
- LD with Mem_ready low 3 cycles in T6 → Read=MDRin=1 for 4 cycles, then T7 MDRout/Gra/Rin. Total 11 cycles.
- ST op=2 → T6 Gra/Rout/MDRin, T7 Write=1, Write never coincident with Read.
- BR op=18 run twice:
  - CON=1 → PCin=1 in T6.
  - CON=0 → T6 Zlowout=1 with PCin=0, and the next state is T0.
- HALT op=27 → HALTED with Halted=1 and Step=15. It holds 5 cycles with Run=0; Run=1 → T0. Opcode 31 → Illegal pulses 1 cycle in T3, then T0.
